vr_delay_throttle: RTL
======================

// Module: vr_delay_throttle
// PURPOSE
// - Synthesizable N-channel valid-ready throttle between a stimulus/producer and a DUT (e.g. fpdiv_scalar).
// - Per channel it registers one transaction and holds it for a pseudo-random 0..MAX_DELAY-1 cycles before presenting it downstream.
// - Replaces the fixed, TB-only random handshake delays with a reusable, seedable, multi-lane block usable in sim and FPGA.
// PARAMETERS
// - NUM_CH     2        number of independent channels
// - DATA_W     64       payload width per channel
// - MAX_DELAY  8        delay range 0..MAX_DELAY-1; power of 2, 2..256
// - LFSR_SEED  16'hACE1 base seed; channel c uses LFSR_SEED+c (0 -> 16'h0001)
// PORTS
// - clk          in   1              clock, rising edge
// - rst_n        in   1              async active-low reset
// - cfg_en_i     in   1              1: random delays; 0: delay forced to 0
// - up_valid_i   in   NUM_CH         upstream valid, bit c = channel c
// - up_ready_o   out  NUM_CH         upstream ready
// - up_data_i    in   NUM_CH*DATA_W  upstream payload, ch c at [c*DATA_W +: DATA_W]
// - dn_valid_o   out  NUM_CH         downstream valid
// - dn_ready_i   in   NUM_CH         downstream ready
// - dn_data_o    out  NUM_CH*DATA_W  downstream payload (registered)
// - xfer_cnt_o   out  NUM_CH*32      completed downstream transfers per ch (stats)
// - stall_cnt_o  out  NUM_CH*32      cycles with dn_valid_o=1 & dn_ready_i=0 per ch (stats)
// BEHAVIOUR
// - Reset (async assert, sync release): all ch state=IDLE, dn_valid_o=0, dn_data_o=0, counters=0, LFSRs=seed.
// - up_ready_o=0 during reset and first cycle after release (init flop); thereafter up_ready_o[c]=(state==IDLE).
// - LFSR per ch: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle after release, independent of traffic.
// - delay = lfsr[$clog2(MAX_DELAY)-1:0] when cfg_en_i=1, else 0; sampled at the accepting edge.
// - FSM per channel:
//   IDLE : up_valid&up_ready -> latch data; delay==0 -> SEND, else cnt=delay -> WAIT.
//   WAIT : cnt decrements each cycle; cnt==1 -> SEND (total delay cycles in WAIT = delay).
//   SEND : dn_valid_o=1, dn_data_o stable; dn_ready_i=1 -> IDLE.
// - Latency up_valid accept -> dn_valid_o high: 1+delay cycles. Throughput at delay 0: one xfer per 2 cycles/ch.
// - dn_valid_o never deasserts before handshake; data unchanged while dn_valid_o=1.
// - dn_ready_i is ignored outside SEND; up_valid_i ignored outside IDLE.
// - cfg_en_i change mid-WAIT does not alter loaded cnt; applies to next accept.
// - Channels fully independent; no ordering between channels.
// - Reset mid-operation: in-flight transactions discarded, no dn_valid_o emitted.
// - Counters saturate at 32'hFFFF_FFFF (no wrap).
// CONFIGURATION
// - VR_THROTTLE_STATS_EN defined: xfer_cnt_o/stall_cnt_o live as above.
// - Not defined: counters not built; xfer_cnt_o and stall_cnt_o tied to 0. Ports always present.
// TESTING
// - Reset release, cfg_en_i=0, ch0 valid with data 64'h3FF0_0000_0000_0000, dn_ready=1 -> up_ready 0 at cycle 0, accept cycle 1, dn_valid cycle 2 with same data.
// - cfg_en_i=0, back-to-back 16 ops on ch0, dn_ready=1 -> 16 outputs in order, every other cycle; xfer_cnt_o[ch0]=16.
// - cfg_en_i=1, MAX_DELAY=8, 1000 ops/ch -> every dn_valid 1..8 cycles after accept; data matches, order preserved per ch.
// - dn_ready=0 for 5 cycles while SEND -> dn_valid held, data stable, stall_cnt_o +5 (macro on) / 0 (off).
// - rst_n pulsed low while ch1 in WAIT -> dn_valid_o=0 immediately, no output for discarded op, counters 0.
// - Same seed, same stimulus, two runs -> identical dn_valid_o timing trace.

Source files
------------

// File: rtl/vr_delay_throttle.sv
// N-channel valid-ready throttle: each lane holds one transaction for a seedable pseudo-random delay.
// Optional statistics counters are built when VR_THROTTLE_STATS_EN is defined; otherwise the stat ports read 0.
module vr_delay_throttle #(
    parameter int          NUM_CH    = 2,
    parameter int          DATA_W    = 64,
    parameter int          MAX_DELAY = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en_i,
    input  logic [NUM_CH-1:0]        up_valid_i,
    output logic [NUM_CH-1:0]        up_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] up_data_i,
    output logic [NUM_CH-1:0]        dn_valid_o,
    input  logic [NUM_CH-1:0]        dn_ready_i,
    output logic [NUM_CH*DATA_W-1:0] dn_data_o,
    output logic [NUM_CH*32-1:0]     xfer_cnt_o,
    output logic [NUM_CH*32-1:0]     stall_cnt_o
);

    localparam int DLY_W = $clog2(MAX_DELAY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic r_init;

    // Holds upstream ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // A zero seed would lock the LFSR, so it is remapped to 1.
        localparam logic [15:0] SEED_RAW = LFSR_SEED + 16'(c);
        localparam logic [15:0] SEED_C   = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

        logic [15:0]       r_lfsr;
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic [DLY_W-1:0]  r_cnt;
        logic [DLY_W-1:0]  w_cnt_nxt;
        logic [DLY_W-1:0]  w_delay;
        logic [DATA_W-1:0] r_data;
        logic              r_dn_valid;
        logic              w_accept;

        assign w_delay  = cfg_en_i ? r_lfsr[DLY_W-1:0] : {DLY_W{1'b0}};
        assign w_accept = up_valid_i[c] & r_init & (r_state == ST_IDLE);

        // Free-running delay source, independent of traffic.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lfsr <= SEED_C;
            end else begin
                r_lfsr <= lfsr_step(r_lfsr);
            end
        end

        // Next-state and delay-counter decode for the channel FSM.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_delay == {DLY_W{1'b0}}) begin
                            w_state_nxt = ST_SEND;
                        end else begin
                            w_state_nxt = ST_WAIT;
                            w_cnt_nxt   = w_delay;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == DLY_W'(1)) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_cnt_nxt = r_cnt - DLY_W'(1);
                    end
                end
                ST_SEND: begin
                    if (dn_ready_i[c]) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {DLY_W{1'b0}};
                end
            endcase
        end

        // State, payload and registered downstream valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_IDLE;
                r_cnt      <= {DLY_W{1'b0}};
                r_data     <= {DATA_W{1'b0}};
                r_dn_valid <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_cnt      <= w_cnt_nxt;
                r_dn_valid <= (w_state_nxt == ST_SEND);
                if (w_accept) begin
                    r_data <= up_data_i[c*DATA_W +: DATA_W];
                end
            end
        end

        assign up_ready_o[c]                 = r_init & (r_state == ST_IDLE);
        assign dn_valid_o[c]                 = r_dn_valid;
        assign dn_data_o[c*DATA_W +: DATA_W] = r_data;

`ifdef VR_THROTTLE_STATS_EN
        logic [31:0] r_xfer_cnt;
        logic [31:0] r_stall_cnt;

        // Saturating transfer and back-pressure counters.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_xfer_cnt  <= 32'd0;
                r_stall_cnt <= 32'd0;
            end else begin
                if (r_dn_valid & dn_ready_i[c]) begin
                    r_xfer_cnt <= sat_inc(r_xfer_cnt);
                end
                if (r_dn_valid & ~dn_ready_i[c]) begin
                    r_stall_cnt <= sat_inc(r_stall_cnt);
                end
            end
        end

        assign xfer_cnt_o[c*32 +: 32]  = r_xfer_cnt;
        assign stall_cnt_o[c*32 +: 32] = r_stall_cnt;
`else
        assign xfer_cnt_o[c*32 +: 32]  = 32'h0000_0000;
        assign stall_cnt_o[c*32 +: 32] = 32'h0000_0000;
`endif
    end

    vr_delay_throttle_chk #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_ready_i (up_ready_o),
        .dn_valid_i (dn_valid_o),
        .dn_ready_i (dn_ready_i),
        .dn_data_i  (dn_data_o)
    );

endmodule

// Protocol checker: downstream valid/data held under back-pressure, never ready and valid together.
module vr_delay_throttle_chk #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic [NUM_CH-1:0]        up_ready_i,
    input logic [NUM_CH-1:0]        dn_valid_i,
    input logic [NUM_CH-1:0]        dn_ready_i,
    input logic [NUM_CH*DATA_W-1:0] dn_data_i
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (dn_valid_i[c] && !dn_ready_i[c]) |=>
            (dn_valid_i[c] && $stable(dn_data_i[c*DATA_W +: DATA_W])));

        a_excl: assert property (@(posedge clk) disable iff (!rst_n)
            !(up_ready_i[c] && dn_valid_i[c]));
    end

endmodule
